truth_table_checker: RTL
========================

Name: truth_table_checker

Overview:
- Hardware sweep-and-check engine for small combinational blocks.
- Drives every input combination onto a DUT's inputs and samples the DUT's single output after a settle delay.
- Compares each sample against a parameterised expected truth table and reports pass/fail, error count and the first failing vector.
- Sits beside combinational blocks on the FPGA as the on-chip counterpart of the simulation stimulus bench: it both drives and checks the DUT.

Parameters:
- N_IN, 3, number of DUT inputs; sweep covers 2^N_IN vectors.
- SETTLE, 2, cycles stim is held before f_in is sampled; legal range 0..15.
- EXPECTED, 8'hE8, expected truth table, width 2^N_IN; bit i = expected F for stim == i. Default is 3-input majority.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  pulse to begin a sweep; honoured only in IDLE or DONE
- stim  output  N_IN  vector driven to DUT inputs; MSB = first DUT input (P), LSB = last (R)
- f_in  input  1  DUT output, sampled in CHECK
- busy  output  1  high from the cycle after an accepted start until the last CHECK
- done  output  1  high in DONE; held until next accepted start or reset
- pass  output  1  valid when done: 1 if err_count == 0
- err_count  output  N_IN+1  number of mismatching vectors, saturates at 2^N_IN
- fail_valid  output  1  at least one mismatch seen in current or last sweep
- first_fail  output  N_IN  stim index of first mismatch; valid when fail_valid

Behaviour:
- Reset: rst_n low at a rising edge forces the following values on the next edge, regardless of state, including mid-sweep:
  - state = IDLE
  - stim = 0, busy = 0, done = 0, pass = 0
  - err_count = 0, fail_valid = 0, first_fail = 0
  - settle counter = 0
- All outputs are registered.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE / DONE:
  - On start = 1: stim <= 0, err_count <= 0, fail_valid <= 0, first_fail <= 0, done <= 0, pass <= 0, busy <= 1, settle counter <= 0.
  - Go to WAIT if SETTLE > 0, else go directly to CHECK.
  - start = 0: hold state and all outputs.
- WAIT:
  - stim held; counter increments each cycle.
  - When counter == SETTLE-1, go to CHECK.
  - Exactly SETTLE cycles are spent in WAIT per vector.
- CHECK (one cycle):
  - Compare f_in against EXPECTED[stim].
  - On mismatch: err_count <= err_count+1 (saturating). If fail_valid == 0, first_fail <= stim and fail_valid <= 1.
  - If stim == 2^N_IN-1: go to DONE with busy <= 0, done <= 1, and pass <= (final err_count == 0); the final err_count includes this cycle's compare.
  - Otherwise: stim <= stim+1, counter <= 0, go to WAIT (or stay in CHECK if SETTLE == 0).
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - done rises 2^N_IN*(SETTLE+1) cycles after the start-accept edge (24 cycles with defaults).
- stim wraps only by explicit reset to 0 at start; it never increments past 2^N_IN-1.
- start while busy (WAIT/CHECK) is ignored; the sweep continues unperturbed.
- start and rst_n low in the same cycle: reset wins.
- f_in is used only in CHECK; its value in other states is don't-care.
- Restart from DONE clears all results on the accept edge.

Test Plan:
- Default params, DUT = majority(P,Q,R), start pulse -> stim steps 0..7, each held 3 cycles; done = 1 at cycle 24; pass = 1, err_count = 0, fail_valid = 0.
- DUT = majority with output inverted only for stim = 5 and stim = 6 -> done, pass = 0, err_count = 2, fail_valid = 1, first_fail = 5.
- DUT output tied 0 -> err_count = 4 (indices 3, 5, 6, 7), first_fail = 3, pass = 0. DUT tied to ~majority -> err_count = 8, first_fail = 0.
- start re-pulsed at cycle 10 of a sweep -> ignored; done still at cycle 24 with unchanged results. Then start again in DONE -> done drops, err_count clears, new sweep completes 24 cycles later.
- rst_n low for one cycle at stim = 4 mid-sweep -> next cycle IDLE, all outputs 0; no activity until next start.
- SETTLE = 0, correct DUT -> stim increments every cycle, done at cycle 8, pass = 1.

Source files
------------

// File: rtl/truth_table_checker_if.sv
// Stimulus/response bundle between a truth_table_checker and its controller/DUT side.
// The checker drives stim and results; the other side supplies start and the DUT output f_in.
interface truth_table_checker_if #(
   parameter int N_IN = 3
);
   logic              start;
   logic [N_IN-1:0]   stim;
   logic              f_in;
   logic              busy;
   logic              done;
   logic              pass;
   logic [N_IN:0]     err_count;
   logic              fail_valid;
   logic [N_IN-1:0]   first_fail;

   modport master (
      output start, f_in,
      input  stim, busy, done, pass, err_count, fail_valid, first_fail
   );

   modport slave (
      input  start, f_in,
      output stim, busy, done, pass, err_count, fail_valid, first_fail
   );
endinterface

// File: rtl/truth_table_checker.sv
// Sweeps every input vector onto a combinational DUT, waits SETTLE cycles, samples f_in
// and compares it with the EXPECTED truth table, keeping error count and first failing vector.
module truth_table_checker #(
   parameter int                      N_IN     = 3,
   parameter int                      SETTLE   = 2,
   parameter logic [(1<<N_IN)-1:0]    EXPECTED = 8'hE8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   truth_table_checker_if.slave  bus
);
   localparam int              N_VEC       = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST_VEC    = N_IN'(N_VEC - 1);
   localparam logic [N_IN:0]   ERR_MAX     = (N_IN+1)'(N_VEC);
   localparam logic [3:0]      SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [N_IN-1:0]   stim_q, stim_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [N_IN:0]     err_count_q, err_count_d;
   logic              fail_valid_q, fail_valid_d;
   logic [N_IN-1:0]   first_fail_q, first_fail_d;

   logic              mismatch;
   logic              last_vec;
   logic [N_IN:0]     err_inc;

   assign mismatch = (state_q == S_CHECK) && (bus.f_in != EXPECTED[stim_q]);
   assign last_vec = (stim_q == LAST_VEC);
   assign err_inc  = (err_count_q == ERR_MAX) ? err_count_q : err_count_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         stim_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_count_q  <= '0;
         fail_valid_q <= 1'b0;
         first_fail_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         stim_q       <= stim_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         err_count_q  <= err_count_d;
         fail_valid_q <= fail_valid_d;
         first_fail_q <= first_fail_d;
      end
   end

   // With SETTLE == 0 the WAIT state is never visited; CHECK repeats once per vector.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) state_d = (SETTLE > 0) ? S_WAIT : S_CHECK;
         end
         S_WAIT: begin
            if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (last_vec)          state_d = S_DONE;
            else if (SETTLE > 0)   state_d = S_WAIT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d        = cnt_q;
      stim_d       = stim_q;
      busy_d       = busy_q;
      done_d       = done_q;
      pass_d       = pass_q;
      err_count_d  = err_count_q;
      fail_valid_d = fail_valid_q;
      first_fail_d = first_fail_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               cnt_d        = '0;
               stim_d       = '0;
               busy_d       = 1'b1;
               done_d       = 1'b0;
               pass_d       = 1'b0;
               err_count_d  = '0;
               fail_valid_d = 1'b0;
               first_fail_d = '0;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 4'd1;
         end
         S_CHECK: begin
            if (mismatch) begin
               err_count_d = err_inc;
               if (!fail_valid_q) begin
                  fail_valid_d = 1'b1;
                  first_fail_d = stim_q;
               end
            end
            // The verdict must include this cycle's compare, so it uses err_count_d.
            if (last_vec) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               pass_d = (err_count_d == '0);
            end else begin
               stim_d = stim_q + 1'b1;
               cnt_d  = '0;
            end
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   assign bus.stim       = stim_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.err_count  = err_count_q;
   assign bus.fail_valid = fail_valid_q;
   assign bus.first_fail = first_fail_q;
endmodule
